// File: rtl/mem_responder.sv
// mem_responder: word-addressed storage endpoint for memory_if with
// fixed read latency (1 or 2), out-of-range err pulse and post-reset clear.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   address         word address (full width compared against DEPTH)
//   wdata           write data
//   write_enable    write strobe
//   read_enable     read strobe
//   rdata           read data, held while rvalid is low
//   rvalid          one-cycle pulse per accepted read
//   err             one-cycle pulse for an out-of-range access
//   busy            high while the array is being cleared after reset
module mem_responder #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  assign in_range = address < ADDR_W'(DEPTH);
  assign idx      = address[IDX_W-1:0];
  assign rd_ok    = (state == READY) && read_enable;
  assign wr_ok    = (state == READY) && write_enable && in_range;

  // Write-first: a same-cycle write to the read address wins.
  // Out-of-range reads still return a (zero) word.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (write_enable) rd_data = wdata;
      else              rd_data = mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
      err   <= 1'b0;
    end else begin
      err <= (state == READY) && !in_range &&
             (read_enable || write_enable);
      unique case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage array has no reset; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_ok)     mem[idx] <= wdata;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1     <= 1'b0;
        d1     <= '0;
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        v1     <= rd_ok;
        if (rd_ok) d1 <= rd_data;
        rvalid <= v1;
        if (v1) rdata <= d1;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= rd_ok;
        if (rd_ok) rdata <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder at latency 1 and 2,
// scoreboard of expected read data / err cycles checked on falling edges.
module tb_mem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    int unsigned cyc;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic        err1, err2;
  logic        busy1, busy2;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  int unsigned qe[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(
    .DATA_W(32), .ADDR_W(32),
    .DEPTH(DEPTH), .READ_LATENCY(1)
  ) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .address(addr), .wdata(wdata),
    .write_enable(we), .read_enable(re),
    .rdata(rdata1), .rvalid(rvalid1),
    .err(err1), .busy(busy1)
  );

  mem_responder #(
    .DATA_W(32), .ADDR_W(32),
    .DEPTH(DEPTH), .READ_LATENCY(2)
  ) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .address(addr), .wdata(wdata),
    .write_enable(we), .read_enable(re),
    .rdata(rdata2), .rvalid(rvalid2),
    .err(err2), .busy(busy2)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic w, logic r,
                    logic [31:0] a, logic [31:0] d);
    logic        ok;
    logic [31:0] x;
    ok    = a < DEPTH;
    we    = w;
    re    = r;
    addr  = a;
    wdata = d;
    if (r) begin
      x = '0;
      if (ok) x = w ? d : model[a[7:0]];
      q1.push_back('{cyc + 1, x});
      q2.push_back('{cyc + 2, x});
    end
    if ((w || r) && !ok) qe.push_back(cyc + 1);
    if (w && ok) model[a[7:0]] = d;
    step();
  endtask

  task automatic idle(int n);
    we = 1'b0;
    re = 1'b0;
    repeat (n) step();
  endtask

  task automatic flush();
    q1.delete();
    q2.delete();
    qe.delete();
    last1 = '0;
    last2 = '0;
  endtask

  task automatic chk_rst_outs(string tag);
    chk({tag, "_rdata1"}, rdata1, 32'h0);
    chk({tag, "_rvalid1"}, {31'h0, rvalid1}, 32'h0);
    chk({tag, "_err1"}, {31'h0, err1}, 32'h0);
    chk({tag, "_busy1"}, {31'h0, busy1}, 32'h1);
    chk({tag, "_rdata2"}, rdata2, 32'h0);
    chk({tag, "_rvalid2"}, {31'h0, rvalid2}, 32'h0);
    chk({tag, "_err2"}, {31'h0, err2}, 32'h0);
    chk({tag, "_busy2"}, {31'h0, busy2}, 32'h1);
  endtask

  // Release reset and check busy stays high exactly DEPTH cycles.
  task automatic clear_wait();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      chk("busy1", {31'h0, busy1}, {31'h0, i < DEPTH});
      chk("busy2", {31'h0, busy2}, {31'h0, i < DEPTH});
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  always @(negedge clk) begin
    logic e1, e2, ee;
    if (rst_n) begin
      e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
      chk("rvalid1", {31'h0, rvalid1}, {31'h0, e1});
      if (e1) begin
        chk("rdata1", rdata1, q1[0].d);
        last1 = q1[0].d;
        void'(q1.pop_front());
      end else begin
        chk("hold1", rdata1, last1);
      end
      e2 = (q2.size() > 0) && (q2[0].cyc == cyc);
      chk("rvalid2", {31'h0, rvalid2}, {31'h0, e2});
      if (e2) begin
        chk("rdata2", rdata2, q2[0].d);
        last2 = q2[0].d;
        void'(q2.pop_front());
      end else begin
        chk("hold2", rdata2, last2);
      end
      ee = (qe.size() > 0) && (qe[0] == cyc);
      chk("err1", {31'h0, err1}, {31'h0, ee});
      chk("err2", {31'h0, err2}, {31'h0, ee});
      if (ee) void'(qe.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_rst_outs("reset");
    clear_wait();

    for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, a, 32'h0);
    idle(3);

    op(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
    op(1'b0, 1'b1, 32'd5, 32'h0);
    idle(3);

    op(1'b1, 1'b1, 32'd7, 32'h1234_5678);
    idle(3);

    op(1'b1, 1'b0, 32'd0, 32'hA5A5_A5A5);
    op(1'b0, 1'b1, 32'd256, 32'h0);
    op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    op(1'b1, 1'b0, 32'd256, 32'h0BAD_0BAD);
    op(1'b1, 1'b1, 32'd257, 32'h1111_1111);
    op(1'b0, 1'b1, 32'd0, 32'h0);
    op(1'b0, 1'b1, 32'd255, 32'h0);
    idle(3);

    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, i, i * 3);
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, i, 32'h0);
    idle(4);

    op(1'b0, 1'b1, 32'd5, 32'h0);
    re = 1'b0;
    #2;
    rst_n = 1'b0;
    flush();
    #1;
    chk_rst_outs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) step();
    chk("midclr_busy1", {31'h0, busy1}, 32'h1);
    chk("midclr_busy2", {31'h0, busy2}, 32'h1);
    rst_n = 1'b0;
    flush();
    #1;
    chk_rst_outs("midclr");
    repeat (2) @(posedge clk);
    #1;
    clear_wait();
    op(1'b0, 1'b1, 32'd5, 32'h0);
    op(1'b0, 1'b1, 32'd0, 32'h0);
    op(1'b0, 1'b1, 32'd7, 32'h0);
    idle(4);

    chk("q1_empty", q1.size(), 32'h0);
    chk("q2_empty", q2.size(), 32'h0);
    chk("qe_empty", qe.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
